// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history cache update path.
package bht_pkg;

  localparam int PC_W        = 10;
  localparam int BHT_INDEX_W = 4;

  // One resolved branch waiting to be written into the cache.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } bht_upd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } bht_state_t;

  // Two PCs land on the same cache line when their index bits agree.
  function automatic logic same_index(input logic [BHT_INDEX_W-1:0] a,
                                      input logic [BHT_INDEX_W-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/bht_update_ctrl_if.sv
// Execute-stage update channel: valid/ready handshake carrying one branch resolution.
interface bht_update_ctrl_if;
  import bht_pkg::*;

  logic            upd_valid;
  logic            upd_ready;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;

  // Execute stage drives the resolution, the update controller answers with ready.
  modport master (output upd_valid, output upd_pc, output upd_taken, input upd_ready);
  modport slave  (input upd_valid, input upd_pc, input upd_taken, output upd_ready);

endinterface

// File: rtl/bht_upd_fifo.sv
// Small circular FIFO of pending cache updates. Every slot is visible so the
// controller can compare all queued PCs against the fetch lookup.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  bht_upd_t                  push_data,
  input  logic                      pop,
  output bht_upd_t                  head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output bht_upd_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]          valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  bht_upd_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  assign head    = mem[rd_ptr];
  assign entries = mem;
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);

  // A slot is live when its distance from the head (mod DEPTH) is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
    end
  end

  // Pointer/occupancy bookkeeping; the caller never pushes when full or pops when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Sequences resolved-branch updates into the branch history cache write port,
// honouring holds and flushes, counting evictions and flagging stale lookups.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  bht_update_ctrl_if.slave       upd,
  input  logic                   hold,
  input  logic                   flush_req,
  output logic                   flush_ack,
  input  logic [PC_W-1:0]        fetch_pc,
  output logic                   lookup_stale,
  output logic                   cache_we,
  output logic [PC_W-1:0]        cache_update_pc,
  output logic                   cache_branch_taken,
  input  logic                   cache_evict,
  output logic [CNT_W-1:0]       evict_count,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] EVICT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] EVICT_MAX = {CNT_W{1'b1}};

  bht_state_t           state;
  logic                 flush_prev;
  logic                 flush_rise;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_clear;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PTR_W:0]       fifo_count;
  bht_upd_t             push_data;
  bht_upd_t             head;
  bht_upd_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]     entry_valid;
  logic                 unused_pc_bits;

  // A held flush request must only be acted on once, so flushes are edge triggered.
  assign flush_rise = flush_req && !flush_prev;

  // Ready looks only at registered occupancy: a pop in the same cycle does not free a slot.
  assign upd.upd_ready = !rst && !fifo_full && (state != FLUSH) && !flush_req;
  assign fifo_push     = upd.upd_valid && upd.upd_ready;
  assign push_data     = '{pc: upd.upd_pc, taken: upd.upd_taken};

  assign cache_we           = (state == ISSUE) && !fifo_empty && !hold && !flush_req;
  assign fifo_pop           = cache_we;
  assign cache_update_pc    = fifo_empty ? '0 : head.pc;
  assign cache_branch_taken = fifo_empty ? 1'b0 : head.taken;

  assign fifo_clear = flush_rise && (state != FLUSH);
  assign pending    = fifo_count;

  // Upper fetch PC bits do not select a cache line, so they never join the compare.
  assign unused_pc_bits = ^fetch_pc[PC_W-1:BHT_INDEX_W];

  bht_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .entries   (entries),
    .valid     (entry_valid)
  );

  // Any live queued update (including the one being written now) on the same line makes the lookup stale.
  always_comb begin
    lookup_stale = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] &&
          same_index(entries[i].pc[BHT_INDEX_W-1:0], fetch_pc[BHT_INDEX_W-1:0])) begin
        lookup_stale = 1'b1;
      end
    end
  end

  // Controller FSM; flush_ack is registered so it lands in the single FLUSH cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_prev <= 1'b0;
      flush_ack  <= 1'b0;
    end else begin
      flush_prev <= flush_req;
      flush_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_rise) begin
            state     <= FLUSH;
            flush_ack <= 1'b1;
          end else if (fifo_push) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_rise) begin
            state     <= FLUSH;
            flush_ack <= 1'b1;
          end else if (fifo_pop && !fifo_push && (fifo_count == CNT_ONE)) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of writes the cache reported as tag misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evict_count <= '0;
    end else if (cache_we && cache_evict && (evict_count != EVICT_MAX)) begin
      evict_count <= evict_count + EVICT_ONE;
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl: a vector table for the basic issue
// path, hand-written sequences for reset, eviction, full/hold, flush and stale
// lookup, and a scoreboard that checks every cache write against accepted pushes.
module tb_bht_update_ctrl;
  import bht_pkg::*;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        flush_req;
  logic [9:0]  fetch_pc;
  logic        cache_evict;

  logic        flush_ack;
  logic        lookup_stale;
  logic        cache_we;
  logic [9:0]  cache_update_pc;
  logic        cache_branch_taken;
  logic [15:0] evict_count;
  logic [2:0]  pending;

  logic        flush_ack2;
  logic        lookup_stale2;
  logic        cache_we2;
  logic [9:0]  cache_update_pc2;
  logic        cache_branch_taken2;
  logic [1:0]  evict_count2;
  logic [2:0]  pending2;

  int n_cmp  = 0;
  int n_fail = 0;

  bht_upd_t sb[$];
  bht_upd_t sb_exp;

  typedef struct {
    logic       v;
    logic [9:0] pc;
    logic       tk;
    logic       hd;
    logic       fl;
    logic [9:0] fpc;
    logic       ev;
    logic       e_ready;
    logic       e_we;
    logic [9:0] e_pc;
    logic       e_tk;
    logic [2:0] e_pend;
    logic       e_stale;
    logic       e_ack;
    logic [15:0] e_evc;
  } vec_t;

  vec_t vecs[5];

  int fh_ready[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int fh_we[11]    = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
  int fh_pend[11]  = '{0, 1, 2, 3, 4, 4, 3, 3, 2, 1, 0};
  int fl_flush[8]  = '{1, 1, 1, 1, 0, 1, 0, 0};
  int fl_ack[8]    = '{0, 1, 0, 0, 0, 0, 1, 0};
  int fl_ready[8]  = '{0, 0, 0, 0, 1, 0, 0, 1};
  int fl_pend[8]   = '{3, 0, 0, 0, 0, 0, 0, 0};

  bht_update_ctrl_if bus();
  bht_update_ctrl_if bus2();

  assign bus2.upd_valid = bus.upd_valid;
  assign bus2.upd_pc    = bus.upd_pc;
  assign bus2.upd_taken = bus.upd_taken;

  bht_update_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .upd                (bus.slave),
    .hold               (hold),
    .flush_req          (flush_req),
    .flush_ack          (flush_ack),
    .fetch_pc           (fetch_pc),
    .lookup_stale       (lookup_stale),
    .cache_we           (cache_we),
    .cache_update_pc    (cache_update_pc),
    .cache_branch_taken (cache_branch_taken),
    .cache_evict        (cache_evict),
    .evict_count        (evict_count),
    .pending            (pending)
  );

  bht_update_ctrl #(.DEPTH(4), .CNT_W(2)) dut_sat (
    .clk                (clk),
    .rst                (rst),
    .upd                (bus2.slave),
    .hold               (hold),
    .flush_req          (flush_req),
    .flush_ack          (flush_ack2),
    .fetch_pc           (fetch_pc),
    .lookup_stale       (lookup_stale2),
    .cache_we           (cache_we2),
    .cache_update_pc    (cache_update_pc2),
    .cache_branch_taken (cache_branch_taken2),
    .cache_evict        (cache_evict),
    .evict_count        (evict_count2),
    .pending            (pending2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge; checks follow 1 ns later.
  task automatic applyStimulus(input logic v, input logic [9:0] pc, input logic tk,
                               input logic hd, input logic fl, input logic [9:0] fpc,
                               input logic ev);
    @(posedge clk);
    #1;
    bus.upd_valid = v;
    bus.upd_pc    = pc;
    bus.upd_taken = tk;
    hold          = hd;
    flush_req     = fl;
    fetch_pc      = fpc;
    cache_evict   = ev;
    #1;
  endtask

  // Scoreboard: compare each cache write against the oldest accepted push, then record new pushes.
  always @(negedge clk) begin
    if (!rst) begin
      if (cache_we) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL sb_underflow: got write pc %0h expected no write at %0t",
                   cache_update_pc, $time);
        end else begin
          sb_exp = sb.pop_front();
          checkOutput("sb_pc", 32'(cache_update_pc), 32'(sb_exp.pc));
          checkOutput("sb_taken", 32'(cache_branch_taken), 32'(sb_exp.taken));
        end
      end
      if (bus.upd_valid && bus.upd_ready) begin
        sb.push_back('{pc: bus.upd_pc, taken: bus.upd_taken});
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 10'h015, 1'b1, 1'b0, 1'b0, 10'h005, 1'b0,
                1'b1, 1'b0, 10'h000, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 10'h022, 1'b0, 1'b0, 1'b0, 10'h005, 1'b1,
                1'b1, 1'b1, 10'h015, 1'b1, 3'd1, 1'b1, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 10'h03F, 1'b1, 1'b0, 1'b0, 10'h002, 1'b0,
                1'b1, 1'b1, 10'h022, 1'b0, 3'd1, 1'b1, 1'b0, 16'd1};
    vecs[3] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h00F, 1'b1,
                1'b1, 1'b1, 10'h03F, 1'b1, 3'd1, 1'b1, 1'b0, 16'd1};
    vecs[4] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h00F, 1'b0,
                1'b1, 1'b0, 10'h000, 1'b0, 3'd0, 1'b0, 1'b0, 16'd2};

    rst           = 1'b1;
    bus.upd_valid = 1'b0;
    bus.upd_pc    = '0;
    bus.upd_taken = 1'b0;
    hold          = 1'b0;
    flush_req     = 1'b0;
    fetch_pc      = '0;
    cache_evict   = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_ready", 32'(bus.upd_ready), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_we", 32'(cache_we), 32'd0);
    checkOutput("rst_evc", 32'(evict_count), 32'd0);
    checkOutput("rst_ack", 32'(flush_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bus.upd_ready), 32'd1);

    // Back-to-back issue, table driven
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].v, vecs[i].pc, vecs[i].tk, vecs[i].hd, vecs[i].fl,
                    vecs[i].fpc, vecs[i].ev);
      checkOutput($sformatf("vec%0d_ready", i), 32'(bus.upd_ready), 32'(vecs[i].e_ready));
      checkOutput($sformatf("vec%0d_we", i), 32'(cache_we), 32'(vecs[i].e_we));
      checkOutput($sformatf("vec%0d_pc", i), 32'(cache_update_pc), 32'(vecs[i].e_pc));
      checkOutput($sformatf("vec%0d_tk", i), 32'(cache_branch_taken), 32'(vecs[i].e_tk));
      checkOutput($sformatf("vec%0d_pend", i), 32'(pending), 32'(vecs[i].e_pend));
      checkOutput($sformatf("vec%0d_stale", i), 32'(lookup_stale), 32'(vecs[i].e_stale));
      checkOutput($sformatf("vec%0d_ack", i), 32'(flush_ack), 32'(vecs[i].e_ack));
      checkOutput($sformatf("vec%0d_evc", i), 32'(evict_count), 32'(vecs[i].e_evc));
    end

    // Asynchronous reset in the middle of a held burst
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 10'(10'h101 + i), 1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    end
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    checkOutput("burst_pending", 32'(pending), 32'd3);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_pending", 32'(pending), 32'd0);
    checkOutput("midrst_we", 32'(cache_we), 32'd0);
    checkOutput("midrst_evc", 32'(evict_count), 32'd0);
    checkOutput("midrst_ready", 32'(bus.upd_ready), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rel_ready", 32'(bus.upd_ready), 32'd1);
    checkOutput("rel_pending", 32'(pending), 32'd0);

    // Eviction counting: 3 of 5 writes evict, plus an evict with no write
    for (int i = 0; i < 7; i++) begin
      applyStimulus((i < 5), 10'(10'h040 + i), i[0], 1'b0, 1'b0, 10'h000,
                    (i == 1 || i == 3 || i == 5 || i == 6));
      checkOutput($sformatf("ev%0d_we", i), 32'(cache_we), 32'((i >= 1 && i <= 5) ? 1 : 0));
    end
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("evc_three", 32'(evict_count), 32'd3);
    checkOutput("evc_sat_three", 32'(evict_count2), 32'd3);
    applyStimulus(1'b1, 10'h050, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    applyStimulus(1'b1, 10'h051, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    checkOutput("evc_five", 32'(evict_count), 32'd5);
    checkOutput("evc_saturated", 32'(evict_count2), 32'd3);

    // Full FIFO under hold, then drain after hold releases
    for (int i = 0; i < 11; i++) begin
      applyStimulus((i < 7), (i < 4) ? 10'(10'h080 + i) : 10'h084, 1'b1,
                    (i < 5), 1'b0, 10'h000, 1'b0);
      checkOutput($sformatf("fh%0d_ready", i), 32'(bus.upd_ready), 32'(fh_ready[i]));
      checkOutput($sformatf("fh%0d_we", i), 32'(cache_we), 32'(fh_we[i]));
      checkOutput($sformatf("fh%0d_pend", i), 32'(pending), 32'(fh_pend[i]));
    end

    // Flush with three queued entries, held request, then a second rising edge
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 10'(10'h0C1 + i), 1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i == 0), 10'h0C4, 1'b1, 1'b0, fl_flush[i][0], 10'h000, 1'b0);
      checkOutput($sformatf("fl%0d_we", i), 32'(cache_we), 32'd0);
      checkOutput($sformatf("fl%0d_ack", i), 32'(flush_ack), 32'(fl_ack[i]));
      checkOutput($sformatf("fl%0d_ready", i), 32'(bus.upd_ready), 32'(fl_ready[i]));
      checkOutput($sformatf("fl%0d_pend", i), 32'(pending), 32'(fl_pend[i]));
      if (i == 0) sb.delete();
    end

    // Stale lookup on a queued update
    applyStimulus(1'b1, 10'h1A5, 1'b1, 1'b1, 1'b0, 10'h2E5, 1'b0);
    checkOutput("st0_stale", 32'(lookup_stale), 32'd0);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h2E5, 1'b0);
    checkOutput("st1_stale", 32'(lookup_stale), 32'd1);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h2E6, 1'b0);
    checkOutput("st2_stale", 32'(lookup_stale), 32'd0);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h2E5, 1'b0);
    checkOutput("st3_we", 32'(cache_we), 32'd1);
    checkOutput("st3_pc", 32'(cache_update_pc), 32'h1A5);
    checkOutput("st3_stale", 32'(lookup_stale), 32'd1);
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h2E5, 1'b0);
    checkOutput("st4_stale", 32'(lookup_stale), 32'd0);
    checkOutput("st4_pending", 32'(pending), 32'd0);

    @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
